aes_round_key_store: RTL and testbench

Round-key sink for the AES-256-CTR datapath. It captures the 15 128-bit round keys streamed out of `keyexpansion`, one key per valid beat, and holds them in an indexed register file. The cipher round engine reads them back by round number with a fixed one-cycle latency. It sits between the key schedule and the round pipeline, so a key is expanded once and then reused for every counter block.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_rk_regfile.sv | 61 ++++++
 rtl/aes_round_key_store.sv | 142 ++++++++++++++
 tb/tb_aes_round_key_store.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-256 round-key storage path.
//   AES_NUM_RK : number of round keys in an AES-256 schedule (14 rounds + 1)
//   AES_RK_W   : round-key width in bits
//   rk_t       : one round key
//   rk_state_e : capture state of the round-key store
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NUM_RK = 15;
  localparam int AES_RK_W   = 128;

  typedef logic [AES_RK_W-1:0] rk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } rk_state_e;

endpackage

// File: rtl/aes_rk_regfile.sv
// ---------------------------------------------------------------------------
// aes_rk_regfile
// NUM_RK x RK_W round-key register file with one synchronous write port and
// one registered read port. A read and a write to the same entry in the same
// cycle return the old contents (read-before-write).
//
// Optional feature macro: AES_RK_ZEROIZE_EN adds a `zeroize` input that
// clears every entry and the read register on the next edge.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset; clears storage and rd_data
//   zeroize  in   (AES_RK_ZEROIZE_EN only) synchronous clear, highest priority
//   wr_en    in   write strobe
//   wr_idx   in   write entry index
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data holds when low
//   rd_idx   in   read entry index
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module aes_rk_regfile
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES_NUM_RK,
  parameter int RK_W   = AES_RK_W
) (
  input  logic            clk,
  input  logic            rst,
`ifdef AES_RK_ZEROIZE_EN
  input  logic            zeroize,
`endif
  input  logic            wr_en,
  input  logic [3:0]      wr_idx,
  input  logic [RK_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [3:0]      rd_idx,
  output logic [RK_W-1:0] rd_data
);

  logic [RK_W-1:0] mem [NUM_RK];

  // Storage and read register share one block: both sample mem before the
  // write lands, which gives read-before-write on a same-index collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RK; i++) mem[i] <= '0;
      rd_data <= '0;
    end
`ifdef AES_RK_ZEROIZE_EN
    else if (zeroize) begin
      for (int i = 0; i < NUM_RK; i++) mem[i] <= '0;
      rd_data <= '0;
    end
`endif
    else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/aes_round_key_store.sv
// ---------------------------------------------------------------------------
// aes_round_key_store
// Captures the AES-256 round keys streamed from the key schedule, one key per
// valid beat, and serves them to the round engine by round number with a
// fixed one-cycle read latency. Reads of already-written entries are allowed
// while capture is still running so early rounds can start.
//
// Optional feature macro: AES_RK_ZEROIZE_EN adds a `zeroize` pulse input that
// wipes all keys and rd_key and returns the store to IDLE. It has priority
// over load and rk_in_valid.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   zeroize      in   (AES_RK_ZEROIZE_EN only) wipe pulse
//   load         in   pulse; restart capture at index 0
//   rk_in_valid  in   round-key beat valid
//   rk_in        in   round key for the beat, schedule order
//   rd_en        in   read request
//   rd_idx       in   round index to read (0..NUM_RK-1)
//   rd_key       out  registered read data
//   rd_valid     out  rd_key carries data from a legal read this cycle
//   rd_err       out  pulse; previous cycle's read was rejected
//   ready        out  all NUM_RK keys stored
//   busy         out  capture in progress
//   ovf_err      out  sticky; a beat arrived outside capture
// ---------------------------------------------------------------------------
module aes_round_key_store
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES_NUM_RK,
  parameter int RK_W   = AES_RK_W
) (
  input  logic            clk,
  input  logic            rst,
`ifdef AES_RK_ZEROIZE_EN
  input  logic            zeroize,
`endif
  input  logic            load,
  input  logic            rk_in_valid,
  input  logic [RK_W-1:0] rk_in,
  input  logic            rd_en,
  input  logic [3:0]      rd_idx,
  output logic [RK_W-1:0] rd_key,
  output logic            rd_valid,
  output logic            rd_err,
  output logic            ready,
  output logic            busy,
  output logic            ovf_err
);

  localparam logic [3:0] IDX_LIM  = 4'(NUM_RK);
  localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

  rk_state_e  state;
  logic [3:0] wr_ptr;

  logic       zero_p0;
  logic       wr_en_p0;
  logic       rd_legal_p0;

`ifdef AES_RK_ZEROIZE_EN
  assign zero_p0 = zeroize;
`else
  assign zero_p0 = 1'b0;
`endif

  // ---- stage p0: request decode against current capture state ----
  // A beat is only stored in FILL and only when neither load nor zeroize
  // override it in the same cycle.
  assign wr_en_p0 = rk_in_valid && !load && !zero_p0 && (state == FILL);

  // In FILL only entries already written (below wr_ptr) are readable.
  always_comb begin
    rd_legal_p0 = 1'b0;
    if (rd_en && (rd_idx < IDX_LIM)) begin
      if (state == READY)
        rd_legal_p0 = 1'b1;
      else if ((state == FILL) && (rd_idx < wr_ptr))
        rd_legal_p0 = 1'b1;
    end
  end

  // ---- stage p1: registered FSM, status and read handshake ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      ovf_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_legal_p0 && !zero_p0;
      rd_err   <= rd_en && !rd_legal_p0 && !zero_p0;

      if (zero_p0) begin
        state  <= IDLE;
        wr_ptr <= '0;
        ready  <= 1'b0;
        busy   <= 1'b0;
      end else if (load) begin
        state   <= FILL;
        wr_ptr  <= '0;
        ready   <= 1'b0;
        busy    <= 1'b1;
        ovf_err <= 1'b0;
      end else if (rk_in_valid) begin
        case (state)
          FILL: begin
            wr_ptr <= wr_ptr + 4'd1;
            if (wr_ptr == LAST_IDX) begin
              state <= READY;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
          default: ovf_err <= 1'b1;
        endcase
      end
    end
  end

  aes_rk_regfile #(
    .NUM_RK (NUM_RK),
    .RK_W   (RK_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
`ifdef AES_RK_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .wr_en   (wr_en_p0),
    .wr_idx  (wr_ptr),
    .wr_data (rk_in),
    .rd_en   (rd_legal_p0),
    .rd_idx  (rd_idx),
    .rd_data (rd_key)
  );

endmodule

// File: tb/tb_aes_round_key_store.sv
// ---------------------------------------------------------------------------
// tb_aes_round_key_store
// Self-checking bench for aes_round_key_store. Read responses are predicted
// when a read is driven and popped from a queue one cycle later; status
// outputs are checked inline by each scenario task.
// Build with +define+AES_RK_ZEROIZE_EN to include the zeroize scenario.
// ---------------------------------------------------------------------------
module tb_aes_round_key_store;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
`ifdef AES_RK_ZEROIZE_EN
  logic       zeroize;
`endif
  logic       load;
  logic       rk_in_valid;
  rk_t        rk_in;
  logic       rd_en;
  logic [3:0] rd_idx;
  rk_t        rd_key;
  logic       rd_valid;
  logic       rd_err;
  logic       ready;
  logic       busy;
  logic       ovf_err;

  always #5 clk = ~clk;

  aes_round_key_store u_dut (
    .clk         (clk),
    .rst         (rst),
`ifdef AES_RK_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .load        (load),
    .rk_in_valid (rk_in_valid),
    .rk_in       (rk_in),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_key      (rd_key),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .ready       (ready),
    .busy        (busy),
    .ovf_err     (ovf_err)
  );

  typedef struct packed {
    logic v;
    logic e;
    rk_t  k;
  } exp_t;

  exp_t  sbq[$];
  int    total = 0;
  int    bad   = 0;
  rk_t   held;           // key rd_key is expected to hold
  logic  rd_ok;          // expected legality of the read being driven
  rk_t   rd_exp;         // expected data for a legal read
  string tname;
  rk_t   set_a[15];
  rk_t   set_b[15];

  // One clock: predict the response to the current read inputs, advance,
  // then pop and compare the response that just became visible.
  task automatic tick();
    exp_t x;
    exp_t y;
    x.v = 1'b0;
    x.e = 1'b0;
    x.k = held;
    if (rd_en) begin
      if (rd_ok) begin
        x.v  = 1'b1;
        x.k  = rd_exp;
        held = rd_exp;
      end else begin
        x.e = 1'b1;
      end
    end
    sbq.push_back(x);
    @(posedge clk);
    #1;
    y = sbq.pop_front();
    total++;
    if (rd_valid !== y.v) begin
      bad++;
      $display("FAIL %s rd_valid got=%0b want=%0b", tname, rd_valid, y.v);
    end
    total++;
    if (rd_err !== y.e) begin
      bad++;
      $display("FAIL %s rd_err got=%0b want=%0b", tname, rd_err, y.e);
    end
    total++;
    if (rd_key !== y.k) begin
      bad++;
      $display("FAIL %s rd_key got=%h want=%h", tname, rd_key, y.k);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic beat(input rk_t k);
    rk_in_valid = 1'b1;
    rk_in       = k;
    tick();
    rk_in_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic ok, input rk_t k);
    rd_en  = 1'b1;
    rd_idx = idx;
    rd_ok  = ok;
    rd_exp = k;
    tick();
    rd_en  = 1'b0;
    rd_ok  = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({ready, busy, ovf_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_status got=%b want=000", {ready, busy, ovf_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ovf();
    tname = "ovf";
    beat(128'hdeadbeef_00000000_cafef00d_12345678);
    total++;
    if (ovf_err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got=%0b want=1", ovf_err);
    end
    total++;
    if ({ready, busy} !== 2'b00) begin
      bad++;
      $display("FAIL ovf_status got=%b want=00", {ready, busy});
    end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (u_dut.u_rf.mem[i] !== '0) begin
        bad++;
        $display("FAIL ovf_mem%0d got=%h want=0", i, u_dut.u_rf.mem[i]);
      end
    end
    do_read(4'd0, 1'b0, '0);
    do_load();
    total++;
    if ({ovf_err, busy, ready} !== 3'b010) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=010", {ovf_err, busy, ready});
    end
  endtask

  task automatic test_fill_and_read();
    tname = "fill";
    do_load();
    total++;
    if ({busy, ready} !== 2'b10) begin
      bad++;
      $display("FAIL fill_busy got=%b want=10", {busy, ready});
    end
    for (int j = 0; j < 3; j++) beat(set_a[j]);
    // Early read: idx 2 is written, idx 3 is not yet.
    do_read(4'd2, 1'b1, set_a[2]);
    do_read(4'd3, 1'b0, '0);
    for (int j = 3; j < 15; j++) begin
      beat(set_a[j]);
      total++;
      if ({ready, busy} !== ((j == 14) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL fill_ready_beat%0d got=%b want=%b", j, {ready, busy},
                 (j == 14) ? 2'b10 : 2'b01);
      end
    end
    for (int i = 0; i < 15; i++) do_read(4'(i), 1'b1, set_a[i]);
    tick();
    do_read(4'd15, 1'b0, '0);
    total++;
    if (rd_key !== set_a[14]) begin
      bad++;
      $display("FAIL idx15_hold got=%h want=%h", rd_key, set_a[14]);
    end
  endtask

  task automatic test_load_collision();
    tname = "collide";
    do_load();
    for (int j = 0; j < 8; j++) beat(set_a[j]);
    load        = 1'b1;
    rk_in_valid = 1'b1;
    rk_in       = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;
    tick();
    load        = 1'b0;
    rk_in_valid = 1'b0;
    total++;
    if ({busy, ready, ovf_err} !== 3'b100) begin
      bad++;
      $display("FAIL collide_status got=%b want=100", {busy, ready, ovf_err});
    end
    for (int j = 0; j < 15; j++) begin
      beat(set_b[j]);
      total++;
      if (ready !== (j == 14)) begin
        bad++;
        $display("FAIL collide_ready_beat%0d got=%0b want=%0b", j, ready, (j == 14));
      end
    end
    for (int i = 0; i < 15; i++) do_read(4'(i), 1'b1, set_b[i]);
  endtask

  task automatic test_async_reset();
    tname = "arst";
    do_load();
    for (int j = 0; j < 5; j++) beat(set_a[j]);
    do_read(4'd4, 1'b1, set_a[4]);
    #3;
    rst = 1'b1;
    #1;
    held = '0;
    total++;
    if ({rd_valid, rd_err, ready, busy, ovf_err} !== 5'b00000) begin
      bad++;
      $display("FAIL arst_status got=%b want=00000",
               {rd_valid, rd_err, ready, busy, ovf_err});
    end
    total++;
    if (rd_key !== '0) begin
      bad++;
      $display("FAIL arst_rd_key got=%h want=0", rd_key);
    end
    tick();
    rst = 1'b0;
    tick();
    do_read(4'd0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      total++;
      if (u_dut.u_rf.mem[i] !== '0) begin
        bad++;
        $display("FAIL arst_mem%0d got=%h want=0", i, u_dut.u_rf.mem[i]);
      end
    end
  endtask

`ifdef AES_RK_ZEROIZE_EN
  task automatic test_zeroize();
    tname = "zeroize";
    do_load();
    for (int j = 0; j < 15; j++) beat(set_a[j]);
    do_read(4'd5, 1'b1, set_a[5]);
    zeroize = 1'b1;
    held    = '0;
    tick();
    zeroize = 1'b0;
    total++;
    if ({ready, busy} !== 2'b00) begin
      bad++;
      $display("FAIL zero_status got=%b want=00", {ready, busy});
    end
    do_read(4'd0, 1'b0, '0);
    do_load();
    beat(set_b[0]);
    do_read(4'd0, 1'b1, set_b[0]);
    do_read(4'd1, 1'b0, '0);
    for (int i = 1; i < 15; i++) begin
      total++;
      if (u_dut.u_rf.mem[i] !== '0) begin
        bad++;
        $display("FAIL zero_mem%0d got=%h want=0", i, u_dut.u_rf.mem[i]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
`ifdef AES_RK_ZEROIZE_EN
    zeroize     = 1'b0;
`endif
    load        = 1'b0;
    rk_in_valid = 1'b0;
    rk_in       = '0;
    rd_en       = 1'b0;
    rd_idx      = '0;
    rd_ok       = 1'b0;
    rd_exp      = '0;
    held        = '0;
    set_a[0] = 128'h642423baa95efb4362d3f2ce993c0904;
    set_a[1] = 128'h150f258aa1fe796841d7b4429c9b5a30;
    for (int i = 2; i < 15; i++)
      set_a[i] = {$urandom, $urandom, $urandom, 32'(i) | 32'h1000_0000};
    for (int i = 0; i < 15; i++)
      set_b[i] = {$urandom, $urandom, $urandom, 32'(i) | 32'h2000_0000};

    test_reset();
    test_ovf();
    test_fill_and_read();
    test_load_collision();
    test_async_reset();
`ifdef AES_RK_ZEROIZE_EN
    test_zeroize();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
